top_accumulator: RTL and testbench
==================================

TOP_ACCUMULATOR -- requirements
Module: top_accumulator

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high; forces every register to its reset value.
REQ-004 Port address, output, 5: memory word address.
REQ-005 Port rden, output, 1: memory read enable.
REQ-006 Port wren, output, 1: memory write enable.
REQ-007 Port ready, output, 1: one-cycle completion strobe.
REQ-008 Port datain, input, 16: memory read data (q).
REQ-009 Port dataout, output, 16: memory write data (accumulated sum).

Function
REQ-010 The attached memory SHALL be treated as 32x16 synchronous RAM: address, data, rden and wren sampled on clk; q valid no later than 2 edges after rden is sampled high.
REQ-011 The block SHALL sum memory words 0..30 into a 16-bit accumulator, modulo 2^16, carry discarded.
REQ-012 The block SHALL write the sum to address 31, pulse ready, then halt until the next reset.
REQ-013 States SHALL be: IDLE, READ, GAP, WR_SETUP, WR, WR_HOLD, DONE, HALT.
REQ-014 IDLE: leaves on the first edge after reset release; next state READ, rden=1.
REQ-015 READ: rden held high for exactly 4 cycles (2-bit counter); on the 4th edge acc <= acc + datain; next state GAP, rden=0.
REQ-016 GAP: one cycle, rden=0. If address < 30: address increments and next state is READ. If address = 30: next state is WR_SETUP with address=31 and dataout=acc.
REQ-017 WR_SETUP: wren=0 for one full cycle; address and dataout stable.
REQ-018 WR: wren=1 for exactly one cycle.
REQ-019 WR_HOLD: wren=0, address held at 31.
REQ-020 DONE: ready=1 for one cycle.
REQ-021 HALT: ready=0, rden=0, wren=0; absorbing state until reset.
REQ-022 Timing: address SHALL change at least one clock period before wren rises, and SHALL NOT change while wren=1.
REQ-023 Timing: dataout SHALL change only on entry to WR_SETUP, at least one period after the last rden rise.
REQ-024 Timing: rden and wren SHALL never be high together.
REQ-025 Latency, counted in rising edges after reset deassertion:
  - word k enters READ at edge 1+5k.
  - WR_SETUP entered at edge 156.
  - wren high from edge 157 to 158.
  - ready high from edge 159 to 160.
REQ-026 Outputs SHALL be registered, with no combinational path from datain to any output.

Reset
REQ-027 On reset assertion, at any time including mid-read or mid-write, the block SHALL immediately set: state=IDLE, address=0, rden=0, wren=0, ready=0, dataout=0x0000, acc=0x0000, counter=0.
REQ-028 After reset release the full sequence SHALL restart from word 0; no partial sum is retained.

Verification
REQ-029 Memory words 0..30 = 0x0001 -> word 31 = 0x001F; ready pulses for 1 cycle at edge 159.
REQ-030 Word i = i for i = 0..30 -> word 31 = 0x01D1 (465); words 0..30 unchanged.
REQ-031 Words 0..30 = 0xFFFF -> word 31 = 0xFFE1 (wrap-around).
REQ-032 Protocol monitor over a full run -> every rden pulse lasts exactly 4 cycles; exactly one wren pulse, to address 31; address stable at least 1 cycle before and during wren; ready high for 1 cycle, then low forever.
REQ-033 Reset asserted at edge 80 (mid-READ), released 2 cycles later, memory as in REQ-030 -> all outputs go to 0 immediately; the sequence restarts and the final word 31 = 0x01D1.

Source files
------------

// File: rtl/top_accumulator.sv
// Sums memory words 0..30 of an attached 32x16 synchronous RAM and
// writes the 16-bit sum (carry discarded) to word 31, then halts.
//
// Ports:
//   clk      in   clock, rising-edge active
//   reset    in   asynchronous active-high reset
//   address  out  [4:0]  memory word address
//   rden     out  memory read enable
//   wren     out  memory write enable
//   ready    out  one-cycle completion strobe
//   datain   in   [15:0] memory read data (q)
//   dataout  out  [15:0] memory write data (accumulated sum)

module top_accumulator (
    input  logic        clk,
    input  logic        reset,
    output logic [4:0]  address,
    output logic        rden,
    output logic        wren,
    output logic        ready,
    input  logic [15:0] datain,
    output logic [15:0] dataout
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        WR_SETUP,
        WR,
        WR_HOLD,
        DONE,
        HALT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] acc;
    logic [15:0] acc_n;
    logic [1:0]  cnt;
    logic [1:0]  cnt_n;
    logic [4:0]  address_n;
    logic        rden_n;
    logic        wren_n;
    logic        ready_n;
    logic [15:0] dataout_n;

    // Every output is a register; the comb block only computes next values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= 16'h0000;
            cnt     <= 2'd0;
            address <= 5'd0;
            rden    <= 1'b0;
            wren    <= 1'b0;
            ready   <= 1'b0;
            dataout <= 16'h0000;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            address <= address_n;
            rden    <= rden_n;
            wren    <= wren_n;
            ready   <= ready_n;
            dataout <= dataout_n;
        end
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        address_n = address;
        rden_n    = rden;
        wren_n    = 1'b0;
        ready_n   = 1'b0;
        dataout_n = dataout;

        unique case (state)
            IDLE: begin
                state_n = READ;
                rden_n  = 1'b1;
                cnt_n   = 2'd0;
            end
            READ: begin
                // The read word is sampled on the fourth edge, which gives
                // the RAM's two-edge read latency a cycle of margin.
                if (cnt == 2'd3) begin
                    acc_n   = acc + datain;
                    state_n = GAP;
                    rden_n  = 1'b0;
                    cnt_n   = 2'd0;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            GAP: begin
                if (address == 5'd30) begin
                    state_n   = WR_SETUP;
                    address_n = 5'd31;
                    dataout_n = acc;
                    rden_n    = 1'b0;
                end else begin
                    state_n   = READ;
                    address_n = address + 5'd1;
                    rden_n    = 1'b1;
                    cnt_n     = 2'd0;
                end
            end
            WR_SETUP: begin
                state_n = WR;
                wren_n  = 1'b1;
            end
            WR: begin
                state_n = WR_HOLD;
            end
            WR_HOLD: begin
                state_n = DONE;
                ready_n = 1'b1;
            end
            DONE: begin
                state_n = HALT;
            end
            HALT: begin
                state_n = HALT;
                rden_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                rden_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_top_accumulator.sv
// Directed bench for top_accumulator with a 2-cycle-latency 32x16 RAM
// model and a background protocol monitor.

module tb_top_accumulator;

    logic        clk;
    logic        reset;
    logic [4:0]  address;
    logic        rden;
    logic        wren;
    logic        ready;
    logic [15:0] datain;
    logic [15:0] dataout;

    int n_cmp;
    int n_bad;
    int edge_no;

    logic [15:0] mem [0:31];
    logic [15:0] q1;
    logic [15:0] q;

    int         rden_len;
    int         wren_cnt;
    int         ready_cnt;
    logic [4:0] prev_addr;
    logic       mon_on;

    top_accumulator dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .rden    (rden),
        .wren    (wren),
        .ready   (ready),
        .datain  (datain),
        .dataout (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: q valid two edges after rden is sampled high.
    always @(posedge clk) begin
        if (wren) mem[address] <= dataout;
        if (rden) q1 <= mem[address];
        q <= q1;
    end
    assign datain = q;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor, sampled 1 time unit after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (reset || !mon_on) begin
            rden_len  = 0;
            prev_addr = address;
        end else begin
            chk("rden_wren_overlap", {31'd0, rden & wren}, 32'd0);
            if (rden) begin
                rden_len++;
            end else if (rden_len != 0) begin
                chk("rden_pulse_len", rden_len, 4);
                rden_len = 0;
            end
            if (wren) begin
                wren_cnt++;
                chk("wren_addr", {27'd0, address}, 32'd31);
                chk("wren_addr_stable", {27'd0, address},
                    {27'd0, prev_addr});
            end
            if (ready) ready_cnt++;
            prev_addr = address;
        end
    end

    task automatic go_to(input int e);
        while (edge_no < e) begin
            @(posedge clk);
            #1;
            edge_no++;
        end
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_address", {27'd0, address}, 32'd0);
        chk("rst_outs", {29'd0, rden, wren, ready}, 32'd0);
        chk("rst_dataout", {16'd0, dataout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        edge_no   = 0;
        wren_cnt  = 0;
        ready_cnt = 0;
        mon_on    = 1'b1;
    endtask

    task automatic full_run(input logic [15:0] exp);
        go_to(1);
        chk("e1_rden", {31'd0, rden}, 32'd1);
        chk("e1_addr", {27'd0, address}, 32'd0);
        go_to(5);
        chk("e5_gap_rden", {31'd0, rden}, 32'd0);
        go_to(6);
        chk("e6_addr", {27'd0, address}, 32'd1);
        go_to(155);
        chk("e155_rden", {31'd0, rden}, 32'd0);
        chk("e155_addr", {27'd0, address}, 32'd30);
        go_to(156);
        chk("e156_addr", {27'd0, address}, 32'd31);
        chk("e156_dataout", {16'd0, dataout}, {16'd0, exp});
        chk("e156_wren", {31'd0, wren}, 32'd0);
        go_to(157);
        chk("e157_wren", {31'd0, wren}, 32'd1);
        go_to(158);
        chk("e158_wren", {31'd0, wren}, 32'd0);
        chk("e158_ready", {31'd0, ready}, 32'd0);
        chk("mem31", {16'd0, mem[31]}, {16'd0, exp});
        go_to(159);
        chk("e159_ready", {31'd0, ready}, 32'd1);
        go_to(160);
        chk("e160_ready", {31'd0, ready}, 32'd0);
        go_to(180);
        chk("halt_outs", {29'd0, rden, wren, ready}, 32'd0);
        chk("wren_pulses", wren_cnt, 1);
        chk("ready_pulses", ready_cnt, 1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        edge_no   = 0;
        mon_on    = 1'b0;
        rden_len  = 0;
        wren_cnt  = 0;
        ready_cnt = 0;
        prev_addr = 5'd0;
        q1        = 16'h0000;
        q         = 16'h0000;
        reset     = 1'b1;

        // All ones: 31 * 1 = 0x001F
        for (int i = 0; i < 32; i++) mem[i] = 16'h0001;
        mem[31] = 16'h0000;
        do_reset();
        full_run(16'h001F);

        // Ramp: 0+1+...+30 = 465 = 0x01D1
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
        mem[31] = 16'h0000;
        do_reset();
        full_run(16'h01D1);
        chk("ramp_w0", {16'd0, mem[0]}, 32'd0);
        chk("ramp_w17", {16'd0, mem[17]}, 32'd17);
        chk("ramp_w30", {16'd0, mem[30]}, 32'd30);

        // Wrap: 31 * 0xFFFF mod 2^16 = 0xFFE1
        for (int i = 0; i < 32; i++) mem[i] = 16'hFFFF;
        mem[31] = 16'h0000;
        do_reset();
        full_run(16'hFFE1);

        // Mid-read reset, then full restart with the ramp pattern
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
        mem[31] = 16'h0000;
        do_reset();
        go_to(79);
        chk("mid_rden", {31'd0, rden}, 32'd1);
        chk("mid_addr", {27'd0, address}, 32'd15);
        #2;
        mon_on = 1'b0;
        reset  = 1'b1;
        #1;
        chk("async_addr", {27'd0, address}, 32'd0);
        chk("async_outs", {29'd0, rden, wren, ready}, 32'd0);
        chk("async_dataout", {16'd0, dataout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        edge_no   = 0;
        wren_cnt  = 0;
        ready_cnt = 0;
        mon_on    = 1'b1;
        full_run(16'h01D1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
